// File: rtl/lvt_port_scheduler.sv
// lvt_port_scheduler
// Round-robin front end for a 2-write/1-read LVT-banked memory. Each cycle up
// to two writes and one read are granted among N requesters. Same-address
// collisions within a cycle go to the earlier op in scan order. Memory-side
// port signals are registered. Read data returns tagged with the requester ID
// after the memory read latency.
module lvt_port_scheduler #(
    parameter int N      = 4,
    parameter int IDW    = 2,
    parameter int AW     = 7,
    parameter int DW     = 5,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req_valid,
    input  logic [N-1:0]      req_we,
    input  logic [N*AW-1:0]   req_addr,
    input  logic [N*DW-1:0]   req_wdata,
    output logic [N-1:0]      req_ready,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [DW-1:0]     rsp_data,
    output logic              wr0_en,
    output logic [AW-1:0]     wr0_addr,
    output logic [DW-1:0]     wr0_data,
    output logic              wr1_en,
    output logic [AW-1:0]     wr1_addr,
    output logic [DW-1:0]     wr1_data,
    output logic              rd0_en,
    output logic [AW-1:0]     rd0_addr,
    input  logic [DW-1:0]     rd0_data
);

    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] rr_ptr_nxt;
    logic           any_grant;
    logic [N-1:0]   grant;

    // Arbitration results for this cycle
    logic           w0_sel;
    logic [AW-1:0]  w0_addr_c;
    logic [DW-1:0]  w0_data_c;
    logic           w1_sel;
    logic [AW-1:0]  w1_addr_c;
    logic [DW-1:0]  w1_data_c;
    logic           r_sel;
    logic [AW-1:0]  r_addr_c;
    logic [IDW-1:0] r_id_c;

    // Read-response pipeline: stage 0 is the issue register (rd0_en),
    // stage RD_LAT lines up with valid rd0_data.
    logic           vld_p [0:RD_LAT];
    logic [IDW-1:0] id_p  [0:RD_LAT];

    // Round-robin scan granting up to two writes and one read, earlier op wins collisions
    always_comb begin
        int            idx;
        int            nxt;
        logic [AW-1:0] a;
        logic [IDW-1:0] last_idx;
        idx       = 0;
        nxt       = 0;
        a         = '0;
        last_idx  = '0;
        grant     = '0;
        any_grant = 1'b0;
        w0_sel    = 1'b0;
        w0_addr_c = '0;
        w0_data_c = '0;
        w1_sel    = 1'b0;
        w1_addr_c = '0;
        w1_data_c = '0;
        r_sel     = 1'b0;
        r_addr_c  = '0;
        r_id_c    = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            a = req_addr[idx*AW +: AW];
            if (req_valid[idx]) begin
                if (req_we[idx]) begin
                    // A write needs a free write port and no earlier grant on the same address
                    if (!w1_sel && !(w0_sel && w0_addr_c == a) && !(r_sel && r_addr_c == a)) begin
                        grant[idx] = 1'b1;
                        any_grant  = 1'b1;
                        last_idx   = IDW'(idx);
                        if (!w0_sel) begin
                            w0_sel    = 1'b1;
                            w0_addr_c = a;
                            w0_data_c = req_wdata[idx*DW +: DW];
                        end else begin
                            w1_sel    = 1'b1;
                            w1_addr_c = a;
                            w1_data_c = req_wdata[idx*DW +: DW];
                        end
                    end
                end else begin
                    // A read needs the read port free and no earlier write to the same address
                    if (!r_sel && !(w0_sel && w0_addr_c == a) && !(w1_sel && w1_addr_c == a)) begin
                        grant[idx] = 1'b1;
                        any_grant  = 1'b1;
                        last_idx   = IDW'(idx);
                        r_sel      = 1'b1;
                        r_addr_c   = a;
                        r_id_c     = IDW'(idx);
                    end
                end
            end
        end
        nxt = int'(last_idx) + 1;
        if (nxt >= N) begin
            nxt = 0;
        end
        rr_ptr_nxt = any_grant ? IDW'(nxt) : rr_ptr;
    end

    // Grants are suppressed while reset is held
    assign req_ready = rst ? {N{1'b0}} : grant;

    // Round-robin pointer: one past the last granted requester
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else begin
            rr_ptr <= rr_ptr_nxt;
        end
    end

    // Issue stage: register memory write ports; idle ports keep their addr/data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr0_en   <= 1'b0;
            wr0_addr <= '0;
            wr0_data <= '0;
            wr1_en   <= 1'b0;
            wr1_addr <= '0;
            wr1_data <= '0;
            rd0_addr <= '0;
        end else begin
            wr0_en <= w0_sel;
            wr1_en <= w1_sel;
            if (w0_sel) begin
                wr0_addr <= w0_addr_c;
                wr0_data <= w0_data_c;
            end
            if (w1_sel) begin
                wr1_addr <= w1_addr_c;
                wr1_data <= w1_data_c;
            end
            if (r_sel) begin
                rd0_addr <= r_addr_c;
            end
        end
    end

    // Response pipeline: valid and ID shift alongside the memory read latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j <= RD_LAT; j++) begin
                vld_p[j] <= 1'b0;
                id_p[j]  <= '0;
            end
        end else begin
            vld_p[0] <= r_sel;
            id_p[0]  <= r_id_c;
            for (int j = 1; j <= RD_LAT; j++) begin
                vld_p[j] <= vld_p[j-1];
                id_p[j]  <= id_p[j-1];
            end
        end
    end

    assign rd0_en    = vld_p[0];
    assign rsp_valid = vld_p[RD_LAT];
    assign rsp_id    = id_p[RD_LAT];
    // Data passes straight through from the memory, forced to 0 when no response is due
    assign rsp_data  = vld_p[RD_LAT] ? rd0_data : '0;

endmodule

// File: tb/tb_lvt_port_scheduler.sv
// Directed testbench for lvt_port_scheduler with a small behavioural memory
// (RD_LAT = 1) attached to its memory-side ports.
module tb_lvt_port_scheduler;

    localparam int N      = 4;
    localparam int IDW    = 2;
    localparam int AW     = 7;
    localparam int DW     = 5;
    localparam int RD_LAT = 1;

    logic              clk;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_we;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N-1:0]      req_ready;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [DW-1:0]     rsp_data;
    logic              wr0_en, wr1_en, rd0_en;
    logic [AW-1:0]     wr0_addr, wr1_addr, rd0_addr;
    logic [DW-1:0]     wr0_data, wr1_data;
    logic [DW-1:0]     rd0_data;

    logic [DW-1:0]     mem [0:(1<<AW)-1];

    int tests;
    int fails;

    lvt_port_scheduler #(.N(N), .IDW(IDW), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(rd0_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: writes commit on the edge after issue, read data one cycle after rd0_en
    always @(posedge clk) begin
        if (wr0_en) mem[wr0_addr] <= wr0_data;
        if (wr1_en) mem[wr1_addr] <= wr1_data;
        if (rd0_en) rd0_data <= mem[rd0_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]           = 1'b1;
        req_we[i]              = we;
        req_addr[i*AW +: AW]   = a;
        req_wdata[i*DW +: DW]  = d;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_reqs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_reqs();
        set_req(0, 1'b1, 7'd1, 5'd1);
        set_req(1, 1'b0, 7'd2, 5'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
        tests++; if ({wr0_en, wr1_en, rd0_en} !== 3'b000) begin fails++; $display("FAIL reset_en got %b exp 000", {wr0_en, wr1_en, rd0_en}); end
        tests++; if ({wr0_addr, wr0_data, wr1_addr, wr1_data, rd0_addr} !== '0) begin fails++; $display("FAIL reset_addr_data got %h exp 0", {wr0_addr, wr0_data, wr1_addr, wr1_data, rd0_addr}); end
        tests++; if ({rsp_valid, rsp_id, rsp_data} !== '0) begin fails++; $display("FAIL reset_rsp got %h exp 0", {rsp_valid, rsp_id, rsp_data}); end
        clear_reqs();
        rst = 1'b0;
    endtask

    task automatic test_single_write();
        do_reset();
        @(negedge clk);
        set_req(0, 1'b1, 7'd5, 5'h1A);
        #1;
        tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL sw_ready got %b exp 0001", req_ready); end
        @(negedge clk);
        clear_reqs();
        tests++; if ({wr0_en, wr0_addr, wr0_data} !== {1'b1, 7'd5, 5'h1A}) begin fails++; $display("FAIL sw_wr0 got %b/%0d/%h exp 1/5/1a", wr0_en, wr0_addr, wr0_data); end
        tests++; if ({wr1_en, rd0_en} !== 2'b00) begin fails++; $display("FAIL sw_other_en got %b exp 00", {wr1_en, rd0_en}); end
        @(negedge clk);
        tests++; if ({wr0_en, wr0_addr, wr0_data} !== {1'b0, 7'd5, 5'h1A}) begin fails++; $display("FAIL sw_idle_hold got %b/%0d/%h exp 0/5/1a", wr0_en, wr0_addr, wr0_data); end
    endtask

    task automatic test_dual_write();
        do_reset();
        @(negedge clk);
        set_req(0, 1'b1, 7'd3,  5'd1);
        set_req(1, 1'b1, 7'd9,  5'd2);
        set_req(2, 1'b1, 7'd12, 5'd3);
        #1;
        tests++; if (req_ready !== 4'b0011) begin fails++; $display("FAIL dw_ready0 got %b exp 0011", req_ready); end
        @(negedge clk);
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        tests++; if ({wr0_en, wr0_addr, wr0_data} !== {1'b1, 7'd3, 5'd1}) begin fails++; $display("FAIL dw_wr0 got %b/%0d/%0d exp 1/3/1", wr0_en, wr0_addr, wr0_data); end
        tests++; if ({wr1_en, wr1_addr, wr1_data} !== {1'b1, 7'd9, 5'd2}) begin fails++; $display("FAIL dw_wr1 got %b/%0d/%0d exp 1/9/2", wr1_en, wr1_addr, wr1_data); end
        #1;
        tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL dw_ready1 got %b exp 0100", req_ready); end
        @(negedge clk);
        req_valid[2] = 1'b0;
        tests++; if ({wr0_en, wr0_addr, wr0_data, wr1_en} !== {1'b1, 7'd12, 5'd3, 1'b0}) begin fails++; $display("FAIL dw_stalled got %b/%0d/%0d/%b exp 1/12/3/0", wr0_en, wr0_addr, wr0_data, wr1_en); end
        // rr_ptr is now 3: requester 3 beats requester 0 on a shared address
        set_req(0, 1'b1, 7'd50, 5'd7);
        set_req(3, 1'b1, 7'd50, 5'd8);
        #1;
        tests++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL dw_ptr3 got %b exp 1000", req_ready); end
        @(negedge clk);
        req_valid[3] = 1'b0;
        tests++; if ({wr0_en, wr0_addr, wr0_data} !== {1'b1, 7'd50, 5'd8}) begin fails++; $display("FAIL dw_ptr3_wr0 got %b/%0d/%0d exp 1/50/8", wr0_en, wr0_addr, wr0_data); end
        #1;
        tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL dw_wrap got %b exp 0001", req_ready); end
        @(negedge clk);
        clear_reqs();
    endtask

    task automatic test_collision();
        do_reset();
        @(negedge clk);
        set_req(1, 1'b1, 7'd40, 5'h0A);
        set_req(2, 1'b1, 7'd40, 5'h15);
        #1;
        tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL col_ready0 got %b exp 0010", req_ready); end
        @(negedge clk);
        req_valid[1] = 1'b0;
        tests++; if ({wr0_en, wr0_data, wr1_en} !== {1'b1, 5'h0A, 1'b0}) begin fails++; $display("FAIL col_first got %b/%h/%b exp 1/0a/0", wr0_en, wr0_data, wr1_en); end
        #1;
        tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL col_ready1 got %b exp 0100", req_ready); end
        @(negedge clk);
        clear_reqs();
        tests++; if ({wr0_en, wr0_addr, wr0_data} !== {1'b1, 7'd40, 5'h15}) begin fails++; $display("FAIL col_second got %b/%0d/%h exp 1/40/15", wr0_en, wr0_addr, wr0_data); end
        @(negedge clk);
        tests++; if (mem[40] !== 5'h15) begin fails++; $display("FAIL col_mem got %h exp 15", mem[40]); end
    endtask

    task automatic test_read();
        do_reset();
        @(negedge clk);
        set_req(0, 1'b1, 7'd7, 5'h11);
        @(negedge clk);
        clear_reqs();
        @(negedge clk);
        set_req(2, 1'b0, 7'd7, 5'd0);
        #1;
        tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL rd_ready got %b exp 0100", req_ready); end
        @(negedge clk);
        clear_reqs();
        tests++; if ({rd0_en, rd0_addr, rsp_valid} !== {1'b1, 7'd7, 1'b0}) begin fails++; $display("FAIL rd_issue got %b/%0d/%b exp 1/7/0", rd0_en, rd0_addr, rsp_valid); end
        @(negedge clk);
        tests++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd2, 5'h11}) begin fails++; $display("FAIL rd_rsp got %b/%0d/%h exp 1/2/11", rsp_valid, rsp_id, rsp_data); end
        tests++; if (rd0_en !== 1'b0) begin fails++; $display("FAIL rd_en_drop got %b exp 0", rd0_en); end
        @(negedge clk);
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rd_single got %b exp 0", rsp_valid); end
    endtask

    task automatic test_wr_rd_conflict();
        do_reset();
        @(negedge clk);
        set_req(0, 1'b1, 7'd20, 5'h0C);
        set_req(3, 1'b0, 7'd20, 5'd0);
        #1;
        tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL wrc_ready0 got %b exp 0001", req_ready); end
        @(negedge clk);
        req_valid[0] = 1'b0;
        tests++; if ({wr0_en, wr0_addr, rd0_en} !== {1'b1, 7'd20, 1'b0}) begin fails++; $display("FAIL wrc_write got %b/%0d/%b exp 1/20/0", wr0_en, wr0_addr, rd0_en); end
        #1;
        tests++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL wrc_ready1 got %b exp 1000", req_ready); end
        @(negedge clk);
        clear_reqs();
        tests++; if ({rd0_en, rd0_addr} !== {1'b1, 7'd20}) begin fails++; $display("FAIL wrc_issue got %b/%0d exp 1/20", rd0_en, rd0_addr); end
        @(negedge clk);
        tests++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd3, 5'h0C}) begin fails++; $display("FAIL wrc_rsp got %b/%0d/%h exp 1/3/0c", rsp_valid, rsp_id, rsp_data); end
    endtask

    task automatic test_reset_inflight();
        do_reset();
        @(negedge clk);
        set_req(1, 1'b0, 7'd7, 5'd0);
        #1;
        tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL rif_ready got %b exp 0010", req_ready); end
        @(negedge clk);
        tests++; if (rd0_en !== 1'b1) begin fails++; $display("FAIL rif_issue got %b exp 1", rd0_en); end
        rst = 1'b1;
        req_valid = 4'b1111;
        req_we    = 4'b1111;
        #1;
        tests++; if ({req_ready, rd0_en, wr0_en, wr1_en, rsp_valid} !== 8'b0) begin fails++; $display("FAIL rif_during got %b exp 00000000", {req_ready, rd0_en, wr0_en, wr1_en, rsp_valid}); end
        @(negedge clk);
        tests++; if ({rsp_valid, rsp_id, rsp_data} !== '0) begin fails++; $display("FAIL rif_dropped got %b/%0d/%h exp 0/0/0", rsp_valid, rsp_id, rsp_data); end
        clear_reqs();
        rst = 1'b0;
        @(negedge clk);
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rif_after got %b exp 0", rsp_valid); end
        // Pointer restarts at 0: requesters 1 and 2 win over 3
        set_req(1, 1'b1, 7'd60, 5'd1);
        set_req(2, 1'b1, 7'd61, 5'd2);
        set_req(3, 1'b1, 7'd62, 5'd3);
        #1;
        tests++; if (req_ready !== 4'b0110) begin fails++; $display("FAIL rif_ptr got %b exp 0110", req_ready); end
        @(negedge clk);
        clear_reqs();
        tests++; if ({wr0_addr, wr1_addr} !== {7'd60, 7'd61}) begin fails++; $display("FAIL rif_ports got %0d/%0d exp 60/61", wr0_addr, wr1_addr); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        clear_reqs();
        test_reset();
        test_single_write();
        test_dual_write();
        test_collision();
        test_read();
        test_wr_rd_conflict();
        test_reset_inflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
